rr_arbiter_multi: RTL and testbench
===================================

Name: rr_arbiter_multi

Overview:
- Parametrised N-requester round-robin arbiter that issues up to G grants per cycle. Intended for superscalar issue/select and writeback-port allocation.
- Successor to the fixed 3/4-way single-grant arbiters.
- Adds multi-grant per cycle, non-power-of-2 N, and a downstream ready handshake with grant locking under backpressure.
- Pointer advances past the last granted requester only when the grant set is accepted.

Parameters:
- N, 8, number of requesters; N >= 2, any integer, not restricted to powers of 2.
- G, 2, maximum grants per cycle; 1 <= G <= N.
- RST_PTR, 0, pointer value at reset; 0 <= RST_PTR < N.
- IDXW, $clog2(N), derived localparam; index width.
- CNTW, $clog2(G+1), derived localparam; grant count width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req  in  N  request vector; bit i = requester i.
- req_valid  in  1  qualifies req; when 0, no new grants are issued.
- rotate  in  1  advances the pointer by 1 without a grant.
- grant_ready  in  1  downstream accepts the current grant set.
- grant  out  N  union mask of all granted requesters.
- grant_idx  out  G*IDXW  lane k index at bits [k*IDXW +: IDXW].
- grant_lane_valid  out  G  lane k carries a grant; lanes fill from lane 0 with no gaps.
- grant_count  out  CNTW  popcount of grant_lane_valid.
- grant_valid  out  1  OR of grant_lane_valid.
- ptr_o  out  IDXW  current highest-priority position (debug/verification).

Behaviour:
- State: ptr (IDXW bits), locked (1 bit), captured lane registers (G indices, G valids).
- Reset (rst=1 at posedge): ptr <= RST_PTR; locked <= 0; captured lanes cleared.
- While rst=1, all outputs are forced to 0, except ptr_o, which shows the register value.
- Rotation order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1. Wrap is explicit modulo N, not a bit-width overflow (required for N=5 and similar).
- Unlocked path, zero latency:
  - lane k takes the k-th set bit of req in rotation order, for k < G.
  - Lanes beyond the number of set bits are invalid, with grant_idx = 0.
  - grant = OR of one-hot(idx) over the valid lanes.
  - req_valid=0 or req=0 gives grant_valid=0.
- Locked path: outputs come from the captured registers; req and req_valid are ignored.
- Unlocked -> locked: grant_valid=1 and grant_ready=0 captures the lanes and sets locked. Outputs do not change value across the transition.
- Locked -> unlocked: grant_ready=1 while locked clears locked. The pointer update uses the captured lanes.
- Pointer update on accept (grant_valid=1 and grant_ready=1): ptr <= (idx of the highest valid lane + 1) mod N.
- rotate=1 without an accept: ptr <= (ptr + 1) mod N.
- accept and rotate in the same cycle: the accept update wins and rotate is dropped.
- While locked and grant_ready=0: ptr is frozen and rotate is ignored.
- grant_ready while grant_valid=0 has no effect. No grant is issued from invalid lanes.
- Protocol: a requester keeps req high until it is granted and accepted. Dropping req while locked is a protocol violation; the arbiter still presents the locked grant.
- Output invariants:
  - Valid lanes hold distinct indices, ordered by rotation distance from ptr.
  - grant_count never exceeds G.
  - grant_count equals the popcount of grant.

Test Plan:
- N=8, G=2, reset, req=8'hFF, req_valid=1, grant_ready=1 for 4 cycles -> lanes (0,1), (2,3), (4,5), (6,7); grant_count=2 each cycle; ptr_o sequence 2, 4, 6, 0.
- Wrap: ptr=6, req=8'b0100_0001, ready=1 -> lane0=6, lane1=0, grant=8'h41; next ptr=1.
- Backpressure: ptr=0, req=8'h0C, ready=0 for 3 cycles while req changes to 8'h30 -> grant stays 8'h0C with lanes (2,3) and ptr stays 0. Then ready=1 -> ptr=4; next cycle grants lanes (4,5).
- Rotate, N=5, RST_PTR=3, req_valid=0:
  - rotate twice -> ptr_o 4, then 0.
  - Then rotate=1 with req=5'b00100, ready=1 -> grant idx 2; ptr=3 (accept wins over rotate).
- Partial fill: req=8'h10, G=2 -> lane0 idx 4 valid; lane1 invalid with idx 0; grant_count=1; grant=8'h10.
- Reset mid-lock: locked with grant 8'h0C, then rst=1 for 1 cycle -> grant_valid=0 during reset, locked cleared, ptr=RST_PTR. After reset, grants are recomputed from the live req.

Source files
------------

// File: rtl/rr_arbiter_multi_if.sv
// rr_arbiter_multi_if: request/grant bundle between requesters and the multi-grant arbiter
interface rr_arbiter_multi_if #(
  parameter int N = 8,
  parameter int G = 2
);
  localparam int IDXW = $clog2(N);
  localparam int CNTW = $clog2(G + 1);
  logic [N-1:0]      req;
  logic              req_valid;
  logic              rotate;
  logic              grant_ready;
  logic [N-1:0]      grant;
  logic [G*IDXW-1:0] grant_idx;
  logic [G-1:0]      grant_lane_valid;
  logic [CNTW-1:0]   grant_count;
  logic              grant_valid;
  logic [IDXW-1:0]   ptr_o;
  modport master (
    output req, req_valid, rotate, grant_ready,
    input  grant, grant_idx, grant_lane_valid, grant_count, grant_valid, ptr_o
  );
  modport slave (
    input  req, req_valid, rotate, grant_ready,
    output grant, grant_idx, grant_lane_valid, grant_count, grant_valid, ptr_o
  );
endinterface

// File: rtl/rr_arbiter_multi.sv
// rr_arbiter_multi: N-way round-robin arbiter issuing up to G grants per cycle,
// holding the grant set stable while the consumer back-pressures.
module rr_arbiter_multi #(
  parameter int N       = 8,
  parameter int G       = 2,
  parameter int RST_PTR = 0
) (
  input logic               clk,
  input logic               rst,
  rr_arbiter_multi_if.slave bus
);
  localparam int IDXW = $clog2(N);
  localparam int CNTW = $clog2(G + 1);
  typedef enum logic {S_OPEN, S_LOCK} state_t;
  state_t            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d, hi;
  logic [G*IDXW-1:0] u_idx, s_idx, cap_idx_q, cap_idx_d;
  logic [G-1:0]      u_val, s_val, cap_val_q, cap_val_d;
  logic [N-1:0]      s_grant;
  logic [CNTW-1:0]   s_cnt;
  logic              s_gv, accept;
  // Walk requesters in rotation order with an explicit modulo-N wrap.
  always_comb begin
    int cnt;
    int pos;
    u_idx = '0;
    u_val = '0;
    cnt   = 0;
    pos   = 0;
    for (int d = 0; d < N; d++) begin
      pos = int'(ptr_q) + d;
      pos = (pos >= N) ? pos - N : pos;
      if (bus.req_valid && bus.req[pos] && cnt < G) begin
        u_idx[cnt*IDXW +: IDXW] = pos[IDXW-1:0];
        u_val[cnt]              = 1'b1;
        cnt                     = cnt + 1;
      end
    end
  end
  always_comb begin
    s_idx   = (state_q == S_LOCK) ? cap_idx_q : u_idx;
    s_val   = (state_q == S_LOCK) ? cap_val_q : u_val;
    s_grant = '0;
    s_cnt   = '0;
    hi      = '0;
    for (int k = 0; k < G; k++) begin
      if (s_val[k]) begin
        s_grant[s_idx[k*IDXW +: IDXW]] = 1'b1;
        s_cnt                          = s_cnt + CNTW'(1);
        hi                             = s_idx[k*IDXW +: IDXW];
      end
    end
    s_gv   = |s_val;
    accept = s_gv && bus.grant_ready;
  end
  always_comb begin
    state_d   = state_q;
    cap_idx_d = cap_idx_q;
    cap_val_d = cap_val_q;
    if (state_q == S_OPEN && s_gv && !bus.grant_ready) begin
      state_d   = S_LOCK;
      cap_idx_d = u_idx;
      cap_val_d = u_val;
    end
    if (state_q == S_LOCK && bus.grant_ready) state_d = S_OPEN;
    ptr_d = accept ? ((hi == IDXW'(N-1)) ? '0 : hi + IDXW'(1)) :
            (bus.rotate && state_q == S_OPEN) ? ((ptr_q == IDXW'(N-1)) ? '0 : ptr_q + IDXW'(1)) :
            ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_OPEN;
      ptr_q     <= IDXW'(RST_PTR);
      cap_idx_q <= '0;
      cap_val_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cap_idx_q <= cap_idx_d;
      cap_val_q <= cap_val_d;
    end
  end
  assign bus.grant            = rst ? '0 : s_grant;
  assign bus.grant_idx        = rst ? '0 : s_idx;
  assign bus.grant_lane_valid = rst ? '0 : s_val;
  assign bus.grant_count      = rst ? '0 : s_cnt;
  assign bus.grant_valid      = rst ? 1'b0 : s_gv;
  assign bus.ptr_o            = ptr_q;
endmodule

// File: tb/tb_rr_arbiter_multi.sv
// tb_rr_arbiter_multi: directed stimulus with a queued scoreboard for the 8-way arbiter
// plus direct checks of a 5-way instance for modulo-5 rotation.
module tb_rr_arbiter_multi;
  typedef struct packed {
    logic [7:0] g;
    logic [5:0] idx;
    logic [1:0] lv;
    logic [1:0] cnt;
    logic [2:0] ptr;
  } exp_t;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  rr_arbiter_multi_if #(.N(8), .G(2)) a();
  rr_arbiter_multi_if #(.N(5), .G(2)) b();
  rr_arbiter_multi #(.N(8), .G(2), .RST_PTR(0)) dut_a (.clk(clk), .rst(rst_a), .bus(a));
  rr_arbiter_multi #(.N(5), .G(2), .RST_PTR(3)) dut_b (.clk(clk), .rst(rst_b), .bus(b));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push(input logic [7:0] g, input logic [2:0] i0, input logic [2:0] i1,
                      input logic [1:0] lv, input logic [1:0] cnt, input logic [2:0] ptr);
    q.push_back('{g: g, idx: {i1, i0}, lv: lv, cnt: cnt, ptr: ptr});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    exp_t act, e;
    if (a.grant_valid === 1'b1) begin
      act = {a.grant, a.grant_idx, a.grant_lane_valid, a.grant_count, a.ptr_o};
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got %h expected none", act);
      end else begin
        e = q.pop_front();
        if (act !== e) begin
          fails++;
          $display("FAIL sb_grant: got g=%h idx=%h lv=%b cnt=%0d ptr=%0d expected g=%h idx=%h lv=%b cnt=%0d ptr=%0d",
                   act.g, act.idx, act.lv, act.cnt, act.ptr, e.g, e.idx, e.lv, e.cnt, e.ptr);
        end
      end
    end
  end
  initial begin
    a.req = '0; a.req_valid = 1'b0; a.rotate = 1'b0; a.grant_ready = 1'b0;
    b.req = '0; b.req_valid = 1'b0; b.rotate = 1'b0; b.grant_ready = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();
    a.req = 8'hFF; a.req_valid = 1'b1; a.grant_ready = 1'b1;
    #1;
    chk("rst_gv", 32'(a.grant_valid), 32'd0);
    chk("rst_grant", 32'(a.grant), 32'd0);
    chk("rst_lanes", 32'({a.grant_lane_valid, a.grant_count, a.grant_idx}), 32'd0);
    tick();
    chk("rst_ptr", 32'(a.ptr_o), 32'd0);
    rst_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(8'h03 << (2*i), 3'(2*i), 3'(2*i+1), 2'b11, 2'd2, 3'(2*i));
      tick();
      chk("full_ptr", 32'(a.ptr_o), 32'((2*i+2) % 8));
    end
    for (int i = 0; i < 3; i++) begin
      push(8'h03 << (2*i), 3'(2*i), 3'(2*i+1), 2'b11, 2'd2, 3'(2*i));
      tick();
    end
    a.req = 8'h41;
    push(8'h41, 3'd6, 3'd0, 2'b11, 2'd2, 3'd6);
    tick();
    chk("wrap_ptr", 32'(a.ptr_o), 32'd1);
    a.req = 8'hFF; a.req_valid = 1'b0; a.rotate = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("rv0_gv", 32'(a.grant_valid), 32'd0);
      tick();
    end
    chk("rot_ptr", 32'(a.ptr_o), 32'd0);
    a.rotate = 1'b0; a.req_valid = 1'b1; a.req = 8'h00;
    #1;
    chk("req0_gv", 32'(a.grant_valid), 32'd0);
    tick();
    chk("req0_ptr", 32'(a.ptr_o), 32'd0);
    a.req = 8'h0C; a.grant_ready = 1'b0;
    push(8'h0C, 3'd2, 3'd3, 2'b11, 2'd2, 3'd0);
    tick();
    a.req = 8'h30; a.rotate = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push(8'h0C, 3'd2, 3'd3, 2'b11, 2'd2, 3'd0);
      tick();
      chk("lock_ptr", 32'(a.ptr_o), 32'd0);
    end
    a.grant_ready = 1'b1;
    push(8'h0C, 3'd2, 3'd3, 2'b11, 2'd2, 3'd0);
    tick();
    chk("unlock_ptr", 32'(a.ptr_o), 32'd4);
    a.rotate = 1'b0;
    push(8'h30, 3'd4, 3'd5, 2'b11, 2'd2, 3'd4);
    tick();
    chk("post_lock_ptr", 32'(a.ptr_o), 32'd6);
    a.req = 8'h10;
    push(8'h10, 3'd4, 3'd0, 2'b01, 2'd1, 3'd6);
    tick();
    chk("partial_ptr", 32'(a.ptr_o), 32'd5);
    a.req = 8'h0C; a.grant_ready = 1'b0;
    push(8'h0C, 3'd2, 3'd3, 2'b11, 2'd2, 3'd5);
    tick();
    rst_a = 1'b1; a.req = 8'h30;
    #1;
    chk("midrst_gv", 32'(a.grant_valid), 32'd0);
    chk("midrst_grant", 32'(a.grant), 32'd0);
    tick();
    chk("midrst_ptr", 32'(a.ptr_o), 32'd0);
    rst_a = 1'b0; a.grant_ready = 1'b1;
    push(8'h30, 3'd4, 3'd5, 2'b11, 2'd2, 3'd0);
    tick();
    chk("relive_ptr", 32'(a.ptr_o), 32'd6);
    a.req_valid = 1'b0;
    chk("b_rst_ptr", 32'(b.ptr_o), 32'd3);
    rst_b = 1'b0; b.req = 5'b11111; b.rotate = 1'b1;
    #1;
    chk("b_rv0_gv", 32'(b.grant_valid), 32'd0);
    tick();
    chk("b_rot1", 32'(b.ptr_o), 32'd4);
    tick();
    chk("b_rot2", 32'(b.ptr_o), 32'd0);
    b.req = 5'b00100; b.req_valid = 1'b1; b.grant_ready = 1'b1;
    #1;
    chk("b_idx0", 32'(b.grant_idx[2:0]), 32'd2);
    chk("b_lv", 32'(b.grant_lane_valid), 32'b01);
    chk("b_grant", 32'(b.grant), 32'h04);
    chk("b_cnt", 32'(b.grant_count), 32'd1);
    tick();
    chk("b_acc_ptr", 32'(b.ptr_o), 32'd3);
    @(negedge clk);
    #1;
    chk("sb_drain", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
